// File: rtl/pc_trace_monitor.sv
// Run monitor for the single-cycle MIPS core: counts cycles/retires, detects program end or
// cycle-budget timeout, and keeps a circular trace of the most recent retired PCs.
`timescale 1ns/1ps
module pc_trace_monitor #(
  parameter int                     PC_WIDTH        = 32,
  parameter int                     INSTR_WIDTH     = 32,
  parameter int                     TRACE_DEPTH     = 8,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR      = 32'h0000000C,
  parameter int                     SELF_LOOP_COUNT = 3,
  parameter int                     MAX_CYCLES      = 100,
  parameter int                     CNT_WIDTH       = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             retire,
  input  logic [PC_WIDTH-1:0]              pc,
  input  logic [INSTR_WIDTH-1:0]           instruction,
  input  logic                             clear,
  input  logic [$clog2(TRACE_DEPTH)-1:0]   rd_idx,
  output logic [PC_WIDTH-1:0]              rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]     trace_count,
  output logic [CNT_WIDTH-1:0]             cycle_count,
  output logic [CNT_WIDTH-1:0]             retire_count,
  output logic                             running,
  output logic                             halted,
  output logic                             timeout,
  output logic [PC_WIDTH-1:0]              halt_pc
);

  localparam int IDX_W  = $clog2(TRACE_DEPTH);
  localparam int LOOP_W = $clog2(SELF_LOOP_COUNT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [IDX_W:0]     TRACE_FULL  = (IDX_W + 1)'(TRACE_DEPTH);
  localparam logic [LOOP_W-1:0]  LOOP_HALT   = LOOP_W'(SELF_LOOP_COUNT);
  localparam logic [CNT_WIDTH-1:0] CYCLE_LIMIT = CNT_WIDTH'(MAX_CYCLES);
  localparam bit                 TIMEOUT_EN  = (MAX_CYCLES != 0);

  logic [1:0]           state_r,   state_nxt_s;
  logic [CNT_WIDTH-1:0] cycle_r,   cycle_nxt_s,  cycle_inc_s;
  logic [CNT_WIDTH-1:0] retire_r,  retire_nxt_s;
  logic [IDX_W:0]       tcount_r,  tcount_nxt_s;
  logic [IDX_W-1:0]     wptr_r,    wptr_nxt_s,   rd_ptr_s;
  logic [PC_WIDTH-1:0]  halt_pc_r, halt_pc_nxt_s;
  logic [PC_WIDTH-1:0]  last_pc_r, last_pc_nxt_s;
  logic [LOOP_W-1:0]    loop_r,    loop_nxt_s,   loop_step_s;
  logic                 active_s, take_s, halt_s, expire_s, mem_we_s;
  logic [PC_WIDTH-1:0]  mem_r [TRACE_DEPTH];

  // Next-state and datapath update; an IDLE retire is handled exactly like a RUN retire.
  always_comb begin
    active_s = 1'b0;
    case (state_r)
      ST_IDLE:    active_s = retire;
      ST_RUN:     active_s = 1'b1;
      ST_HALTED:  active_s = 1'b0;
      ST_TIMEOUT: active_s = 1'b0;
      default:    active_s = 1'b0;
    endcase
    take_s = active_s & retire;

    // The first retire after IDLE always starts a fresh run of equal PCs.
    if ((state_r == ST_RUN) && (pc == last_pc_r)) begin
      loop_step_s = loop_r + LOOP_W'(1);
    end else begin
      loop_step_s = LOOP_W'(1);
    end

    halt_s      = take_s && ((instruction == HALT_INSTR) || (loop_step_s == LOOP_HALT));
    cycle_inc_s = cycle_r + CNT_WIDTH'(1);
    expire_s    = TIMEOUT_EN && active_s && !halt_s && (cycle_inc_s == CYCLE_LIMIT);

    state_nxt_s   = state_r;
    cycle_nxt_s   = cycle_r;
    retire_nxt_s  = retire_r;
    tcount_nxt_s  = tcount_r;
    wptr_nxt_s    = wptr_r;
    halt_pc_nxt_s = halt_pc_r;
    last_pc_nxt_s = last_pc_r;
    loop_nxt_s    = loop_r;
    mem_we_s      = 1'b0;

    if (clear) begin
      state_nxt_s   = ST_IDLE;
      cycle_nxt_s   = '0;
      retire_nxt_s  = '0;
      tcount_nxt_s  = '0;
      wptr_nxt_s    = '0;
      halt_pc_nxt_s = '0;
      last_pc_nxt_s = '0;
      loop_nxt_s    = '0;
    end else begin
      if (active_s) begin
        cycle_nxt_s = cycle_inc_s;
      end else begin
        cycle_nxt_s = cycle_r;
      end

      if (take_s) begin
        mem_we_s      = 1'b1;
        retire_nxt_s  = retire_r + CNT_WIDTH'(1);
        wptr_nxt_s    = wptr_r + IDX_W'(1);
        tcount_nxt_s  = (tcount_r == TRACE_FULL) ? tcount_r : tcount_r + (IDX_W + 1)'(1);
        last_pc_nxt_s = pc;
        loop_nxt_s    = loop_step_s;
      end else begin
        mem_we_s = 1'b0;
      end

      // Halt takes priority over a timeout landing on the same cycle.
      if (halt_s) begin
        state_nxt_s   = ST_HALTED;
        halt_pc_nxt_s = pc;
      end else if (expire_s) begin
        state_nxt_s   = ST_TIMEOUT;
        halt_pc_nxt_s = take_s ? pc : last_pc_r;
      end else if (active_s) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = state_r;
      end
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cycle_r   <= '0;
      retire_r  <= '0;
      tcount_r  <= '0;
      wptr_r    <= '0;
      halt_pc_r <= '0;
      last_pc_r <= '0;
      loop_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cycle_r   <= cycle_nxt_s;
      retire_r  <= retire_nxt_s;
      tcount_r  <= tcount_nxt_s;
      wptr_r    <= wptr_nxt_s;
      halt_pc_r <= halt_pc_nxt_s;
      last_pc_r <= last_pc_nxt_s;
      loop_r    <= loop_nxt_s;
    end
  end

  // Trace storage is deliberately not reset; entries beyond trace_count are stale.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wptr_r] <= pc;
    end
  end

  assign rd_ptr_s     = wptr_r - IDX_W'(1) - rd_idx;
  assign rd_pc        = mem_r[rd_ptr_s];
  assign trace_count  = tcount_r;
  assign cycle_count  = cycle_r;
  assign retire_count = retire_r;
  assign halt_pc      = halt_pc_r;
  assign running      = (state_r == ST_RUN);
  assign halted       = (state_r == ST_HALTED);
  assign timeout      = (state_r == ST_TIMEOUT);

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Self-checking bench for pc_trace_monitor: directed table, hand sequences for the multi-cycle
// corners, and randomized traffic checked against a history-based reference model.
`timescale 1ns/1ps
module tb_pc_trace_monitor;
  localparam int          DEPTH = 8;
  localparam int          MAXC  = 100;
  localparam int          LOOPN = 3;
  localparam logic [31:0] HALT  = 32'h0000000C;
  localparam logic [31:0] NOP   = 32'h20080001;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_TOUT = 3;

  logic        clk = 1'b0;
  logic        reset, retire, clear;
  logic [31:0] pc, instruction;
  logic [2:0]  rd_idx;
  logic [31:0] rd_pc, cycle_count, retire_count, halt_pc;
  logic [3:0]  trace_count;
  logic        running, halted, timeout;

  pc_trace_monitor dut (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .instruction(instruction),
    .clear(clear), .rd_idx(rd_idx), .rd_pc(rd_pc), .trace_count(trace_count),
    .cycle_count(cycle_count), .retire_count(retire_count), .running(running),
    .halted(halted), .timeout(timeout), .halt_pc(halt_pc)
  );

  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain history of retired PCs since the last clear/reset.
  int          m_state;
  int unsigned m_cycles, m_retires;
  logic [31:0] m_halt_pc;
  logic [31:0] hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_cycles = 0; m_retires = 0; m_halt_pc = 32'h0;
    hist.delete();
  endtask

  task automatic model_step(input bit clr, input bit ret, input logic [31:0] p, input logic [31:0] ins);
    int run;
    bit hit;
    if (clr) begin
      model_reset();
      return;
    end
    if (m_state == M_IDLE && ret) m_state = M_RUN;
    if (m_state != M_RUN) return;
    m_cycles++;
    hit = 1'b0;
    if (ret) begin
      m_retires++;
      hist.push_back(p);
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != p) break;
        run++;
      end
      hit = (ins == HALT) || (run >= LOOPN);
    end
    if (hit) begin
      m_state = M_HALT; m_halt_pc = p;
    end else if (MAXC != 0 && m_cycles == MAXC) begin
      m_state = M_TOUT; m_halt_pc = hist[hist.size() - 1];
    end
  endtask

  task automatic check_model(input string name);
    int tc;
    chk({name, ".running"}, running, m_state == M_RUN);
    chk({name, ".halted"}, halted, m_state == M_HALT);
    chk({name, ".timeout"}, timeout, m_state == M_TOUT);
    chk({name, ".cycles"}, cycle_count, m_cycles);
    chk({name, ".retires"}, retire_count, m_retires);
    chk({name, ".halt_pc"}, halt_pc, m_halt_pc);
    tc = (hist.size() > DEPTH) ? DEPTH : hist.size();
    chk({name, ".trace_count"}, trace_count, tc);
    for (int i = 0; i < tc; i++) begin
      rd_idx = 3'(i);
      #1;
      chk({name, ".rd_pc"}, rd_pc, hist[hist.size() - 1 - i]);
    end
  endtask

  task automatic step(input bit clr, input bit ret, input logic [31:0] p, input logic [31:0] ins,
                      input string name);
    clear = clr; retire = ret; pc = p; instruction = ins;
    @(posedge clk);
    model_step(clr, ret, p, ins);
    #1;
    check_model(name);
  endtask

  typedef struct {
    bit clr; bit ret; logic [31:0] pc; logic [31:0] ins;
    bit e_run; bit e_halt; logic [31:0] e_cyc; logic [31:0] e_ret; logic [31:0] e_hpc;
    logic [3:0] e_tc; logic [31:0] e_rd0; logic [31:0] e_rdold;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [31:0] p, ins, prev;
    bit          ret, clr;
    logic [2:0]  idx;

    tbl[0] = '{1'b0, 1'b1, 32'h00,  NOP,  1'b1, 1'b0, 32'd1, 32'd1, 32'h00, 4'd1, 32'h00, 32'h00};
    tbl[1] = '{1'b0, 1'b1, 32'h04,  NOP,  1'b1, 1'b0, 32'd2, 32'd2, 32'h00, 4'd2, 32'h04, 32'h00};
    tbl[2] = '{1'b0, 1'b1, 32'h08,  NOP,  1'b1, 1'b0, 32'd3, 32'd3, 32'h00, 4'd3, 32'h08, 32'h00};
    tbl[3] = '{1'b0, 1'b1, 32'h0C,  HALT, 1'b0, 1'b1, 32'd4, 32'd4, 32'h0C, 4'd4, 32'h0C, 32'h00};
    tbl[4] = '{1'b0, 1'b1, 32'h100, NOP,  1'b0, 1'b1, 32'd4, 32'd4, 32'h0C, 4'd4, 32'h0C, 32'h00};
    tbl[5] = '{1'b1, 1'b1, 32'h10,  NOP,  1'b0, 1'b0, 32'd0, 32'd0, 32'h00, 4'd0, 32'h00, 32'h00};
    tbl[6] = '{1'b0, 1'b1, 32'h10,  NOP,  1'b1, 1'b0, 32'd1, 32'd1, 32'h00, 4'd1, 32'h10, 32'h10};
    tbl[7] = '{1'b0, 1'b1, 32'h10,  NOP,  1'b1, 1'b0, 32'd2, 32'd2, 32'h00, 4'd2, 32'h10, 32'h10};
    tbl[8] = '{1'b0, 1'b1, 32'h10,  NOP,  1'b0, 1'b1, 32'd3, 32'd3, 32'h10, 4'd3, 32'h10, 32'h10};
    tbl[9] = '{1'b0, 1'b1, 32'h10,  NOP,  1'b0, 1'b1, 32'd3, 32'd3, 32'h10, 4'd3, 32'h10, 32'h10};

    reset = 1'b1; retire = 1'b0; clear = 1'b0; pc = 32'h0; instruction = 32'h0; rd_idx = 3'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset.running", running, 1'b0);
    chk("reset.halted", halted, 1'b0);
    chk("reset.timeout", timeout, 1'b0);
    chk("reset.cycles", cycle_count, 32'd0);
    chk("reset.trace_count", trace_count, 4'd0);
    reset = 1'b0;

    // Directed table: syscall halt, frozen state, clear-beats-retire, jump-to-self halt.
    for (int i = 0; i < 10; i++) begin
      clear = tbl[i].clr; retire = tbl[i].ret; pc = tbl[i].pc; instruction = tbl[i].ins;
      @(posedge clk);
      model_step(tbl[i].clr, tbl[i].ret, tbl[i].pc, tbl[i].ins);
      #1;
      chk("tbl.running", running, tbl[i].e_run);
      chk("tbl.halted", halted, tbl[i].e_halt);
      chk("tbl.timeout", timeout, 1'b0);
      chk("tbl.cycles", cycle_count, tbl[i].e_cyc);
      chk("tbl.retires", retire_count, tbl[i].e_ret);
      chk("tbl.halt_pc", halt_pc, tbl[i].e_hpc);
      chk("tbl.trace_count", trace_count, tbl[i].e_tc);
      if (tbl[i].e_tc != 4'd0) begin
        rd_idx = 3'd0;
        #1;
        chk("tbl.rd_newest", rd_pc, tbl[i].e_rd0);
        idx = 3'(tbl[i].e_tc - 4'd1);
        rd_idx = idx;
        #1;
        chk("tbl.rd_oldest", rd_pc, tbl[i].e_rdold);
      end
    end

    // Trace wrap: ten distinct PCs through an eight-entry buffer.
    step(1'b1, 1'b0, 32'h0, NOP, "wrap.clear");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'(4 * i), NOP, "wrap");
    chk("wrap.trace_count", trace_count, 4'd8);
    rd_idx = 3'd0; #1; chk("wrap.rd0", rd_pc, 32'h24);
    rd_idx = 3'd7; #1; chk("wrap.rd7", rd_pc, 32'h08);

    // Timeout with a retire every other cycle; counters freeze afterwards.
    step(1'b1, 1'b0, 32'h0, NOP, "tout.clear");
    for (int k = 1; k <= 100; k++) step(1'b0, (k % 2) == 1, 32'h400 + 32'(4 * ((k - 1) / 2)), NOP, "tout");
    chk("tout.flag", timeout, 1'b1);
    chk("tout.cycles", cycle_count, 32'd100);
    chk("tout.halt_pc", halt_pc, 32'h4C4);
    chk("tout.retires", retire_count, 32'd50);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h900, NOP, "tout.frozen");
    chk("tout.frozen_cycles", cycle_count, 32'd100);
    chk("tout.frozen_retires", retire_count, 32'd50);

    // Syscall on the very cycle the budget runs out: halt wins.
    step(1'b1, 1'b0, 32'h0, NOP, "race.clear");
    for (int k = 1; k <= 99; k++) step(1'b0, 1'b1, 32'h800 + 32'(4 * k), NOP, "race");
    step(1'b0, 1'b1, 32'h1000, HALT, "race.last");
    chk("race.halted", halted, 1'b1);
    chk("race.timeout", timeout, 1'b0);
    chk("race.cycles", cycle_count, 32'd100);
    chk("race.halt_pc", halt_pc, 32'h1000);

    // Asynchronous reset mid-run, then clear out of HALTED and restart.
    step(1'b1, 1'b0, 32'h0, NOP, "arst.clear");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h40 + 32'(4 * k), NOP, "arst.run");
    retire = 1'b0; clear = 1'b0;
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst.running", running, 1'b0);
    chk("arst.cycles", cycle_count, 32'd0);
    chk("arst.retires", retire_count, 32'd0);
    chk("arst.trace_count", trace_count, 4'd0);
    chk("arst.halt_pc", halt_pc, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h20, HALT, "arst.halt");
    chk("arst.halted", halted, 1'b1);
    step(1'b1, 1'b0, 32'h0, NOP, "arst.clr");
    chk("clr.halted", halted, 1'b0);
    chk("clr.trace_count", trace_count, 4'd0);
    step(1'b0, 1'b1, 32'h30, NOP, "clr.restart");
    chk("clr.running", running, 1'b1);
    chk("clr.cycles", cycle_count, 32'd1);

    // Randomized traffic with frequent self-loops, occasional syscalls and clears.
    for (int r = 0; r < 8; r++) begin
      step(1'b1, 1'b0, 32'h0, NOP, "rand.clear");
      prev = 32'h0;
      for (int c = 0; c < 150; c++) begin
        ret = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) p = prev;
        else p = 32'($urandom_range(0, 63)) << 2;
        ins = $urandom;
        if (ins == HALT) ins = NOP;
        if ($urandom_range(0, 39) == 0) ins = HALT;
        clr = ($urandom_range(0, 99) == 0);
        step(clr, ret, p, ins, "rand");
        if (ret && !clr) prev = p;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_trace_monitor.md
Name: pc_trace_monitor

Overview:
- Synthesizable run monitor for the single-cycle MIPS CPU.
- Watches retired PC/instruction pairs and counts cycles and retires.
- Detects program end (syscall or jump-to-self loop) or a cycle-budget timeout, and freezes a circular trace of the last TRACE_DEPTH retired PCs for readback.
- Sits beside the CPU core in both simulation and FPGA builds, replacing fixed-delay run termination with a hardware halt/timeout flag.

Parameters:
- PC_WIDTH, 32, width of pc and trace entries.
- INSTR_WIDTH, 32, width of instruction.
- TRACE_DEPTH, 8, trace entries; power of two, >=2.
- HALT_INSTR, 32'h0000000C, encoding treated as program end (syscall).
- SELF_LOOP_COUNT, 3, consecutive retires at an unchanged PC that count as halt; >=2.
- MAX_CYCLES, 100, cycle budget before timeout; 0 disables timeout.
- CNT_WIDTH, 32, width of the cycle and retire counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- retire  input  1  instruction retired this cycle.
- pc  input  PC_WIDTH  PC of the retiring instruction.
- instruction  input  INSTR_WIDTH  retiring instruction word.
- clear  input  1  synchronous restart to IDLE; same effect as reset.
- rd_idx  input  clog2(TRACE_DEPTH)  trace read index; 0 = most recent.
- rd_pc  output  PC_WIDTH  trace entry at rd_idx (combinational read).
- trace_count  output  clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH.
- cycle_count  output  CNT_WIDTH  cycles spent in RUN.
- retire_count  output  CNT_WIDTH  instructions retired in RUN.
- running  output  1  state==RUN.
- halted  output  1  state==HALTED.
- timeout  output  1  state==TIMEOUT.
- halt_pc  output  PC_WIDTH  PC that caused the halt or timeout.

Behaviour:
- Reset (async) and clear (sync) force: state IDLE, all counters 0, trace_count 0, write pointer 0, halt_pc 0, self-loop counter 0, running/halted/timeout 0. rd_pc reads the stale array; it is only meaningful when rd_idx < trace_count.
- States: IDLE, RUN, HALTED, TIMEOUT. HALTED and TIMEOUT are sticky until reset or clear.
- IDLE -> RUN on the first cycle with retire=1. That retire is processed as a RUN retire in the same cycle: counted, traced and halt-checked, with cycle_count becoming 1.
- In RUN, each cycle: cycle_count += 1. If retire=1: retire_count += 1; write pc at the write pointer, pointer wraps modulo TRACE_DEPTH; trace_count += 1 with saturation.
- Self-loop counter:
  - Resets to 1 on a retire whose pc differs from the previously retired pc, and on the first retire.
  - Increments on a retire with the same pc.
  - Non-retire cycles leave it unchanged.
- Halt (RUN -> HALTED) when either condition holds on the retiring cycle:
  - instruction==HALT_INSTR, or
  - the self-loop counter reaches SELF_LOOP_COUNT including this retire.
  - In both cases halt_pc <= pc, and the halting retire is itself counted and traced.
- Timeout (RUN -> TIMEOUT) when MAX_CYCLES!=0 and cycle_count, after increment, equals MAX_CYCLES on a cycle with no halt; halt_pc <= the last retired pc.
- Simultaneous halt and timeout on the same cycle: HALTED wins.
- In HALTED/TIMEOUT: counters, trace and pointer are frozen; retire is ignored.
- rd_pc = mem[(wptr - 1 - rd_idx) mod TRACE_DEPTH]; pure combinational, usable in any state.
- Counters wrap silently at 2^CNT_WIDTH; no flag is raised.
- Reset asserted mid-RUN: immediate return to IDLE; outputs go to their reset values without waiting for a clock edge.
- clear and retire in the same cycle: clear wins; the retire is dropped.

Test Plan:
- Reset, then retire pc=0,4,8 with non-halt instructions, then pc=0xC with instruction=0x0000000C -> halted=1, halt_pc=0xC, retire_count=4, trace_count=4, rd_idx=0 gives 0xC, rd_idx=3 gives 0x0.
- Retire pc=0x10 three consecutive times (jump-to-self) -> halted=1 after the third retire, halt_pc=0x10; a further retire leaves retire_count=3.
- Retire 10 distinct PCs 0x0..0x24 step 4 with TRACE_DEPTH=8 -> trace_count=8, rd_idx=0 gives 0x24, rd_idx=7 gives 0x8 (wrap correct).
- MAX_CYCLES=100, retire every other cycle with no halt -> timeout=1 exactly when cycle_count=100; halt_pc = last retired pc; counters frozen afterwards.
- Syscall retired on the same cycle cycle_count hits MAX_CYCLES -> halted=1, timeout=0.
- Assert reset asynchronously mid-RUN, then apply clear while HALTED -> outputs zero immediately on reset; after clear, state is IDLE with trace_count=0, and the next retire restarts RUN with cycle_count=1.
